// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: command, response and open-drain bus signals of the I2C master.
// master = command issuer / bus environment side, slave = controller side.
interface i2c_master_ctrl_if #(
    parameter int DIV_W  = 16,
    parameter int ADDR_W = 7
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_start;
    logic              cmd_stop;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              cmd_nack_last;
    logic [DIV_W-1:0]  half_period;
    logic              scl_in;
    logic              sda_in;
    logic              scl_oe;
    logic              sda_oe;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_nack;
    logic              busy;

    modport master (
        output cmd_valid, cmd_start, cmd_stop, cmd_rw, cmd_addr,
        output cmd_wdata, cmd_nack_last, half_period, scl_in, sda_in,
        input  cmd_ready, scl_oe, sda_oe, rsp_valid, rsp_rdata,
        input  rsp_nack, busy
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_stop, cmd_rw, cmd_addr,
        input  cmd_wdata, cmd_nack_last, half_period, scl_in, sda_in,
        output cmd_ready, scl_oe, sda_oe, rsp_valid, rsp_rdata,
        output rsp_nack, busy
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: command-driven I2C master, START/Sr + addr + one byte + STOP or HOLD.
// Optional slave clock stretching is enabled with the macro I2C_CLK_STRETCH_EN.
module i2c_master_ctrl #(
    parameter int DIV_W  = 16,
    parameter int ADDR_W = 7
) (
    input logic              clk,
    input logic              reset,
    i2c_master_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, START, RSTRT, ADDR, AACK, DATA, DACK, STOP, HOLD
    } state_t;

    state_t            state;
    logic [1:0]        ph;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  hp;
    logic [DIV_W-1:0]  hp_in;
    logic [2:0]        bit_idx;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic              stop_q;
    logic              nlast_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rx;
    logic              scl_oe_q;
    logic              sda_oe_q;
    logic              rsp_valid_q;
    logic              rsp_nack_q;
    logic [7:0]        rsp_rdata_q;
    logic [ADDR_W:0]   abyte;
    logic              idle_or_hold;
    logic              freeze;

    assign hp_in = (bus.half_period < DIV_W'(2)) ? DIV_W'(2) : bus.half_period;
    assign abyte = {addr_q, rw_q};
    assign idle_or_hold = (state == IDLE) || (state == HOLD);

`ifdef I2C_CLK_STRETCH_EN
    // a released SCL still held low by the slave delays the high half
    assign freeze = !scl_oe_q && !bus.scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = bus.scl_in;
    assign freeze = 1'b0;
`endif

    assign bus.cmd_ready = idle_or_hold;
    assign bus.busy      = (state != IDLE);
    assign bus.scl_oe    = scl_oe_q;
    assign bus.sda_oe    = sda_oe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_nack  = rsp_nack_q;

    // Bus sequencer: each phase lasts one half-period, outputs change on phase entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ph          <= 2'd0;
            cnt         <= '0;
            hp          <= DIV_W'(2);
            bit_idx     <= 3'd7;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            stop_q      <= 1'b0;
            nlast_q     <= 1'b0;
            wdata_q     <= 8'h00;
            rx          <= 8'h00;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_nack_q  <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            rsp_valid_q <= 1'b0;
            if (idle_or_hold) begin
                if (bus.cmd_valid) begin
                    hp         <= hp_in;
                    cnt        <= hp_in - DIV_W'(1);
                    addr_q     <= bus.cmd_addr;
                    rw_q       <= bus.cmd_rw;
                    stop_q     <= bus.cmd_stop;
                    nlast_q    <= bus.cmd_nack_last;
                    wdata_q    <= bus.cmd_wdata;
                    rsp_nack_q <= 1'b0;
                    ph         <= 2'd0;
                    bit_idx    <= 3'd7;
                    if (state == IDLE) begin
                        state    <= START;
                        sda_oe_q <= 1'b1;
                        scl_oe_q <= 1'b0;
                    end else if (bus.cmd_start) begin
                        state    <= RSTRT;
                        sda_oe_q <= 1'b0;
                        scl_oe_q <= 1'b1;
                    end else begin
                        state    <= DATA;
                        scl_oe_q <= 1'b1;
                        sda_oe_q <= bus.cmd_rw ? 1'b0 : ~bus.cmd_wdata[7];
                    end
                end
            end else if (!freeze) begin
                if (cnt != '0) begin
                    cnt <= cnt - DIV_W'(1);
                end else begin
                    cnt <= hp - DIV_W'(1);
                    case (state)
                        START: begin
                            state    <= ADDR;
                            ph       <= 2'd0;
                            scl_oe_q <= 1'b1;
                            sda_oe_q <= ~abyte[7];
                        end
                        RSTRT: begin
                            if (ph == 2'd0) begin
                                ph       <= 2'd1;
                                scl_oe_q <= 1'b0;
                            end else if (ph == 2'd1) begin
                                ph       <= 2'd2;
                                sda_oe_q <= 1'b1;
                            end else begin
                                state    <= ADDR;
                                ph       <= 2'd0;
                                scl_oe_q <= 1'b1;
                                sda_oe_q <= ~abyte[7];
                            end
                        end
                        ADDR: begin
                            if (ph == 2'd0) begin
                                ph       <= 2'd1;
                                scl_oe_q <= 1'b0;
                            end else begin
                                ph       <= 2'd0;
                                scl_oe_q <= 1'b1;
                                if (bit_idx == 3'd0) begin
                                    state    <= AACK;
                                    sda_oe_q <= 1'b0;
                                end else begin
                                    bit_idx  <= bit_idx - 3'd1;
                                    sda_oe_q <= ~abyte[bit_idx - 3'd1];
                                end
                            end
                        end
                        AACK: begin
                            if (ph == 2'd0) begin
                                ph       <= 2'd1;
                                scl_oe_q <= 1'b0;
                            end else begin
                                ph       <= 2'd0;
                                scl_oe_q <= 1'b1;
                                if (bus.sda_in) begin
                                    rsp_nack_q <= 1'b1;
                                    state      <= STOP;
                                    sda_oe_q   <= 1'b1;
                                end else begin
                                    state    <= DATA;
                                    bit_idx  <= 3'd7;
                                    sda_oe_q <= rw_q ? 1'b0 : ~wdata_q[7];
                                end
                            end
                        end
                        DATA: begin
                            if (ph == 2'd0) begin
                                ph       <= 2'd1;
                                scl_oe_q <= 1'b0;
                            end else begin
                                ph       <= 2'd0;
                                scl_oe_q <= 1'b1;
                                if (rw_q) rx <= {rx[6:0], bus.sda_in};
                                if (bit_idx == 3'd0) begin
                                    state    <= DACK;
                                    sda_oe_q <= rw_q ? ~nlast_q : 1'b0;
                                end else begin
                                    bit_idx  <= bit_idx - 3'd1;
                                    sda_oe_q <= rw_q ? 1'b0
                                                     : ~wdata_q[bit_idx - 3'd1];
                                end
                            end
                        end
                        DACK: begin
                            if (ph == 2'd0) begin
                                ph       <= 2'd1;
                                scl_oe_q <= 1'b0;
                            end else begin
                                ph       <= 2'd0;
                                scl_oe_q <= 1'b1;
                                if (rw_q) rsp_rdata_q <= rx;
                                else rsp_nack_q <= bus.sda_in;
                                if (stop_q) begin
                                    state    <= STOP;
                                    sda_oe_q <= 1'b1;
                                end else begin
                                    state       <= HOLD;
                                    sda_oe_q    <= 1'b0;
                                    rsp_valid_q <= 1'b1;
                                end
                            end
                        end
                        STOP: begin
                            if (ph == 2'd0) begin
                                ph       <= 2'd1;
                                scl_oe_q <= 1'b0;
                            end else if (ph == 2'd1) begin
                                ph       <= 2'd2;
                                sda_oe_q <= 1'b0;
                            end else begin
                                state       <= IDLE;
                                ph          <= 2'd0;
                                rsp_valid_q <= 1'b1;
                            end
                        end
                        default: begin
                            state    <= IDLE;
                            scl_oe_q <= 1'b0;
                            sda_oe_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed checks of i2c_master_ctrl against a small bus slave/monitor.
// Stretch expectations follow I2C_CLK_STRETCH_EN when it is defined for the build.
module tb_i2c_master_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    i2c_master_ctrl_if #(.DIV_W(16), .ADDR_W(7)) bus ();

    i2c_master_ctrl #(.DIV_W(16), .ADDR_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // open-drain bus with slave-side stretch and data pull
    logic hold = 1'b0;
    logic s_pull = 1'b0;
    logic scl_l, sda_l;
    assign scl_l = ~bus.scl_oe & ~hold;
    assign sda_l = ~(bus.sda_oe | s_pull);
    assign bus.scl_in = scl_l;
    assign bus.sda_in = sda_l;

    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;
    logic [7:0] rd_byte = 8'h00;
    logic [7:0] mon_b0 = 8'h00;
    logic [7:0] mon_b1 = 8'h00;
    logic       mon_a0 = 1'b0;
    logic       mon_a1 = 1'b0;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    int         nbit = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         stop_bits = 0;
    int         rsp_cnt = 0;

    // bus monitor plus a responding slave
    always @(negedge clk) begin
        if (p_scl && scl_l && p_sda && !sda_l) begin
            start_cnt++;
            nbit = 0;
        end else if (p_scl && scl_l && !p_sda && sda_l) begin
            stop_cnt++;
            stop_bits = nbit;
        end else if (!p_scl && scl_l) begin
            if (nbit < 8) mon_b0 = {mon_b0[6:0], sda_l};
            else if (nbit == 8) mon_a0 = sda_l;
            else if (nbit <= 16) mon_b1 = {mon_b1[6:0], sda_l};
            else if (nbit == 17) mon_a1 = sda_l;
            nbit++;
        end else if (p_scl && !scl_l) begin
            s_pull = 1'b0;
            if (nbit == 8) s_pull = ack_addr;
            else if (nbit >= 9 && nbit <= 16 && mon_b0[0])
                s_pull = ~rd_byte[16 - nbit];
            else if (nbit == 17 && !mon_b0[0]) s_pull = ack_data;
        end
        if (bus.rsp_valid) rsp_cnt++;
        p_scl = scl_l;
        p_sda = sda_l;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic st, input logic sp, input logic rw,
                         input logic [6:0] a, input logic [7:0] wd,
                         input logic nl, input logic [15:0] hp);
        @(negedge clk);
        check("cmd_ready_pre", bus.cmd_ready, 1);
        bus.cmd_start     = st;
        bus.cmd_stop      = sp;
        bus.cmd_rw        = rw;
        bus.cmd_addr      = a;
        bus.cmd_wdata     = wd;
        bus.cmd_nack_last = nl;
        bus.half_period   = hp;
        bus.cmd_valid     = 1'b1;
        @(negedge clk);
        bus.cmd_valid     = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.rsp_valid) break;
        end
        #1;
    endtask

    int cyc, s_start, s_stop, s_rsp, t_edge, exp_edge;

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_start     = 1'b0;
        bus.cmd_stop      = 1'b0;
        bus.cmd_rw        = 1'b0;
        bus.cmd_addr      = 7'h00;
        bus.cmd_wdata     = 8'h00;
        bus.cmd_nack_last = 1'b0;
        bus.half_period   = 16'd4;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_scl_oe", bus.scl_oe, 0);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_nack", bus.rsp_nack, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", bus.cmd_ready, 1);

        // 1: async reset in ADDR bit 4 (high half, SDA driven low)
        issue(1, 1, 0, 7'h50, 8'hA5, 0, 16'd4);
        repeat (33) @(negedge clk);
        check("t1_busy", bus.busy, 1);
        check("t1_scl_high", bus.scl_oe, 0);
        check("t1_sda_low", bus.sda_oe, 1);
        #2 reset = 1'b0;
        #1;
        check("t1_scl_rel", bus.scl_oe, 0);
        check("t1_sda_rel", bus.sda_oe, 0);
        check("t1_busy_rst", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t1_idle_ready", bus.cmd_ready, 1);
        check("t1_idle_busy", bus.busy, 0);

        // 2: write 0x50 / 0xA5 with START+STOP, slave ACKs
        ack_addr = 1'b1;
        ack_data = 1'b1;
        s_start = start_cnt; s_stop = stop_cnt; s_rsp = rsp_cnt;
        issue(1, 1, 0, 7'h50, 8'hA5, 0, 16'd4);
        wait_rsp(cyc);
        check("t2_cycles", cyc, 160);
        check("t2_addr_byte", mon_b0, 8'hA0);
        check("t2_data_byte", mon_b1, 8'hA5);
        check("t2_aack", mon_a0, 0);
        check("t2_dack", mon_a1, 0);
        check("t2_nack", bus.rsp_nack, 0);
        check("t2_busy_end", bus.busy, 0);
        check("t2_starts", start_cnt - s_start, 1);
        check("t2_stops", stop_cnt - s_stop, 1);
        check("t2_stop_bits", stop_bits, 19);
        repeat (4) @(negedge clk);
        #1;
        check("t2_rsp_count", rsp_cnt - s_rsp, 1);

        // 3: same command, address NACKed
        ack_addr = 1'b0;
        s_stop = stop_cnt;
        issue(1, 1, 0, 7'h50, 8'hA5, 0, 16'd4);
        wait_rsp(cyc);
        check("t3_cycles", cyc, 88);
        check("t3_nack", bus.rsp_nack, 1);
        check("t3_aack", mon_a0, 1);
        check("t3_stops", stop_cnt - s_stop, 1);
        check("t3_stop_bits", stop_bits, 10);
        @(negedge clk);
        check("t3_ready", bus.cmd_ready, 1);

        // 4: read 0x50, slave returns 0x3C, master NACKs
        ack_addr = 1'b1;
        rd_byte = 8'h3C;
        s_stop = stop_cnt;
        issue(1, 1, 1, 7'h50, 8'h00, 1, 16'd4);
        wait_rsp(cyc);
        check("t4_cycles", cyc, 160);
        check("t4_addr_byte", mon_b0, 8'hA1);
        check("t4_rdata", bus.rsp_rdata, 8'h3C);
        check("t4_bus_byte", mon_b1, 8'h3C);
        check("t4_master_nack", mon_a1, 1);
        check("t4_nack", bus.rsp_nack, 0);
        check("t4_stops", stop_cnt - s_stop, 1);

        // 5: write 0x11 into HOLD, then read with Sr
        rd_byte = 8'hC3;
        s_start = start_cnt; s_stop = stop_cnt; s_rsp = rsp_cnt;
        issue(1, 0, 0, 7'h50, 8'h11, 0, 16'd4);
        wait_rsp(cyc);
        check("t5_hold_cycles", cyc, 148);
        check("t5_hold_scl", bus.scl_oe, 1);
        check("t5_hold_ready", bus.cmd_ready, 1);
        check("t5_hold_busy", bus.busy, 1);
        check("t5_wr_byte", mon_b1, 8'h11);
        check("t5_wr_nack", bus.rsp_nack, 0);
        repeat (5) @(negedge clk);
        check("t5_hold_scl2", bus.scl_oe, 1);
        check("t5_hold_sda", bus.sda_oe, 0);
        check("t5_no_stop", stop_cnt - s_stop, 0);
        issue(1, 1, 1, 7'h50, 8'h00, 1, 16'd4);
        wait_rsp(cyc);
        check("t5_rd_cycles", cyc, 168);
        check("t5_rdata", bus.rsp_rdata, 8'hC3);
        check("t5_sr_seen", start_cnt - s_start, 2);
        check("t5_stops", stop_cnt - s_stop, 1);
        repeat (2) @(negedge clk);
        #1;
        check("t5_rsp_count", rsp_cnt - s_rsp, 2);

        // 7: half_period below 2 clamps to 2
        issue(1, 1, 0, 7'h50, 8'hA5, 0, 16'd1);
        wait_rsp(cyc);
        check("t7_cycles", cyc, 80);
        check("t7_data_byte", mon_b1, 8'hA5);
        check("t7_nack", bus.rsp_nack, 0);

        // 6: slave holds SCL low for 20 clk at ADDR bit 3 high half
`ifdef I2C_CLK_STRETCH_EN
        exp_edge = 64;
`else
        exp_edge = 44;
`endif
        t_edge = 0;
        issue(1, 1, 0, 7'h50, 8'hA5, 0, 16'd4);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 38) hold = 1'b1;
            if (k == 60) hold = 1'b0;
            if (k == 41) check("t6_scl_released", bus.scl_oe, 0);
            if (k > 41 && t_edge == 0 && bus.scl_oe) t_edge = k;
        end
        check("t6_next_low_edge", t_edge, exp_edge);
        reset = 1'b0;
        #1;
        check("t6_abort_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
